// File: rtl/ucsbece154a_membridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ucsbece154a_membridge                                         |
// | Purpose  : Bridges single-cycle read/write requests from the multicycle  |
// |            RISC-V controller onto a req/ack variable-latency memory bus. |
// |            Stalls the controller while a transaction is outstanding,     |
// |            registers read data, flags misaligned and conflicting access. |
// | Options  : `define UCSBECE154A_MEMBRIDGE_TIMEOUT_EN builds a 16-bit bus   |
// |            timeout counter that aborts REQ after TIMEOUT_CYCLES cycles.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ucsbece154a_membridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req_i,
   input  logic        wr_req_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] wd_i,
   output logic        stall_o,
   output logic [31:0] rd_o,
   output logic        rd_valid_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_adr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [1:0]  c_IDLE     = 2'd0;
   localparam logic [1:0]  c_REQ      = 2'd1;
   localparam logic [1:0]  c_RESP     = 2'd2;
   localparam logic [31:0] c_RD_ERR   = 32'hDEAD_BEEF;

   logic [1:0] r_state;
   logic       r_is_read;   // transaction in flight is a pure read
   logic       r_conflict;  // both requests were high when it was issued

   logic       w_req;
   logic       w_misaligned;

   assign w_req        = rd_req_i | wr_req_i;
   assign w_misaligned = |adr_i[1:0];

   // Freeze the controller from the request cycle until the response cycle
   assign stall_o = ((r_state == c_IDLE) & w_req) | (r_state == c_REQ);

`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
   // Last REQ cycle index before the abort fires (counter starts at 0)
   localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_cnt;
`endif

   // Bridge FSM plus registered bus and response outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_is_read   <= 1'b0;
         r_conflict  <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_adr_o   <= 32'h0;
         mem_wdata_o <= 32'h0;
         rd_o        <= 32'h0;
         rd_valid_o  <= 1'b0;
         err_o       <= 1'b0;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
         r_cnt       <= 16'h0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_req) begin
                  if (w_misaligned) begin
                     // Reject without touching the bus; a write (including a
                     // conflicting pair) leaves rd_o alone
                     r_state <= c_RESP;
                     err_o   <= 1'b1;
                     if (!wr_req_i) begin
                        rd_o       <= 32'h0;
                        rd_valid_o <= 1'b1;
                     end
                  end else begin
                     r_state     <= c_REQ;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= wr_req_i;
                     mem_adr_o   <= {adr_i[31:2], 2'b00};
                     mem_wdata_o <= wd_i;
                     r_is_read   <= ~wr_req_i;
                     r_conflict  <= rd_req_i & wr_req_i;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
                     r_cnt       <= 16'h0;
`endif
                  end
               end
            end
            c_REQ: begin
               if (mem_ack_i) begin
                  // Ack has priority over a coincident timeout
                  r_state   <= c_RESP;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  err_o     <= r_conflict;
                  if (r_is_read) begin
                     rd_o       <= mem_rdata_i;
                     rd_valid_o <= 1'b1;
                  end
               end
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
               else if (r_cnt == c_TO_LAST) begin
                  r_state   <= c_RESP;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  err_o     <= 1'b1;
                  if (r_is_read) begin
                     rd_o       <= c_RD_ERR;
                     rd_valid_o <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            c_RESP: begin
               // The still-held request seen here is stale and is dropped
               r_state    <= c_IDLE;
               rd_valid_o <= 1'b0;
               err_o      <= 1'b0;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

`ifndef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
   // Error read pattern only reachable through the timeout path
   logic w_unused;
   assign w_unused = ^c_RD_ERR;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_membridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ucsbece154a_membridge                                      |
// | Purpose  : Self-checking bench for ucsbece154a_membridge: directed cases  |
// |            followed by randomized transactions against a transaction-    |
// |            level reference model. Timeout cases are compiled in when      |
// |            UCSBECE154A_MEMBRIDGE_TIMEOUT_EN is defined.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ucsbece154a_membridge;

`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req_i, wr_req_i;
   logic [31:0] adr_i, wd_i;
   logic        stall_o;
   logic [31:0] rd_o;
   logic        rd_valid_o, err_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_adr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   int          n_pass = 0;
   int          n_chk  = 0;
   logic [31:0] m_rd;   // model of rd_o

   always #5 clk = ~clk;

   ucsbece154a_membridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .rd_req_i(rd_req_i), .wr_req_i(wr_req_i), .adr_i(adr_i), .wd_i(wd_i),
      .stall_o(stall_o), .rd_o(rd_o), .rd_valid_o(rd_valid_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One controller transaction. Entered and left at posedge+1 of an idle cycle.
   // k = cycles after mem_req_o rises before the memory acks.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] adr,
                      input logic [31:0] wd, input int k, input logic [31:0] rdata);
      logic aligned, timeout, exp_err, exp_rdv, ack_now;
      int   resp;
      aligned = (adr[1:0] == 2'b00);
      timeout = 1'b0;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
      if (aligned && k >= TO) timeout = 1'b1;
`endif
      resp    = !aligned ? 1 : (timeout ? TO + 1 : k + 2);
      exp_err = !aligned || (rd && wr) || timeout;
      exp_rdv = !wr;
      if (!wr) m_rd = !aligned ? 32'h0 : (timeout ? 32'hDEAD_BEEF : rdata);

      rd_req_i = rd; wr_req_i = wr; adr_i = adr; wd_i = wd;
      for (int t = 0; t <= resp; t++) begin
         ack_now     = aligned && !timeout && (t == k + 1);
         // Spurious acks in IDLE (randomly) and in RESP must be ignored
         mem_ack_i   = ack_now || (t == resp) || (t == 0 && $urandom_range(0, 1) == 1);
         mem_rdata_i = ack_now ? rdata : $urandom();
         @(negedge clk);
         chk("stall", {31'h0, stall_o}, {31'h0, (t < resp)});
         if (t == resp) begin
            chk("resp_mem_req", {31'h0, mem_req_o}, 32'h0);
            chk("resp_rd_valid", {31'h0, rd_valid_o}, {31'h0, exp_rdv});
            chk("resp_err", {31'h0, err_o}, {31'h0, exp_err});
            chk("resp_rd", rd_o, m_rd);
         end else if (t > 0 && aligned) begin
            chk("bus_req", {31'h0, mem_req_o}, 32'h1);
            chk("bus_we", {31'h0, mem_we_o}, {31'h0, wr});
            chk("bus_adr", mem_adr_o, adr);
            chk("bus_wdata", mem_wdata_o, wd);
         end else begin
            chk("idle_mem_req", {31'h0, mem_req_o}, 32'h0);
            chk("idle_rd_valid", {31'h0, rd_valid_o}, 32'h0);
         end
         @(posedge clk); #1;
      end
      // Controller advanced; a late ack arrives in IDLE
      rd_req_i = 1'b0; wr_req_i = 1'b0; adr_i = $urandom(); wd_i = $urandom();
      mem_ack_i = 1'b1; mem_rdata_i = $urandom();
      @(negedge clk);
      chk("post_stall", {31'h0, stall_o}, 32'h0);
      chk("post_rd_valid", {31'h0, rd_valid_o}, 32'h0);
      chk("post_err", {31'h0, err_o}, 32'h0);
      chk("post_rd", rd_o, m_rd);
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      chk("late_ack_ignored", {31'h0, mem_req_o}, 32'h0);
      chk("late_ack_rd_valid", {31'h0, rd_valid_o}, 32'h0);
   endtask

   initial begin
      int sel;
      logic [31:0] a;
      reset = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0; adr_i = 32'h0; wd_i = 32'h0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; m_rd = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
      chk("rst_mem_adr", mem_adr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_rd", rd_o, 32'h0);
      chk("rst_rd_valid", {31'h0, rd_valid_o}, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      chk("rst_stall_noreq", {31'h0, stall_o}, 32'h0);
      rd_req_i = 1'b1; #1;
      chk("rst_stall_req", {31'h0, stall_o}, 32'h1);
      rd_req_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0050_0113);
      txn(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 5, 32'hCAFE_0001);
      txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h1111_1111);
      txn(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 1, 32'h2222_2222);
      txn(1'b0, 1'b1, 32'h0000_0031, 32'h7777_7777, 0, 32'h0);
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
      txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 8, 32'h3333_3333);
      txn(1'b1, 1'b0, 32'h0000_0084, 32'h0, TO - 1, 32'h4444_4444);
      txn(1'b0, 1'b1, 32'h0000_0088, 32'h5555_5555, TO, 32'h0);
`endif

      // Reset two cycles into REQ
      rd_req_i = 1'b1; adr_i = 32'h0000_0100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_mem_req", {31'h0, mem_req_o}, 32'h1);
      #2 reset = 1'b0;
      #1;
      m_rd = 32'h0;
      chk("mid_rst_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("mid_rst_mem_we", {31'h0, mem_we_o}, 32'h0);
      chk("mid_rst_mem_adr", mem_adr_o, 32'h0);
      chk("mid_rst_rd", rd_o, 32'h0);
      chk("mid_rst_rd_valid", {31'h0, rd_valid_o}, 32'h0);
      chk("mid_rst_err", {31'h0, err_o}, 32'h0);
      chk("mid_rst_stall_req", {31'h0, stall_o}, 32'h1);
      rd_req_i = 1'b0; #1;
      chk("mid_rst_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("rst_late_ack_req", {31'h0, mem_req_o}, 32'h0);
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      chk("rst_late_ack_valid", {31'h0, rd_valid_o}, 32'h0);
      chk("rst_late_ack_rd", rd_o, 32'h0);
      txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 2, 32'h0BAD_F00D);

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 5);
         a   = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         txn(sel < 3 || sel == 5, sel >= 3, a, $urandom(), $urandom_range(0, 6), $urandom());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
